// File: rtl/load_store_unit.sv
// Load/store initiator for the data-memory port: lane extraction, extension,
// sub-word read-modify-write, alignment/range checking and a held response.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_RMW_RD,
        S_RMW_WAIT,
        S_WR,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic                  signed_q, signed_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_err;
    logic [4:0]            lane_sh;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] merged;

    assign req_idx = {2'b00, req_addr[ADDR_WIDTH-1:2]};

    // Several error causes may coincide, so a plain OR rather than a decoder
    assign req_err = (req_size == 2'd3)
                   || (req_size == 2'd1 && req_addr[0])
                   || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                   || (req_idx >= ADDR_WIDTH'(DATA_DEPTH));

    assign lane_sh  = {addr_q[1:0], 3'b000};
    assign rd_shift = mem_rdata >> lane_sh;

    always_comb begin
        load_val = mem_rdata;
        case (size_q)
            2'd0:    load_val = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    load_val = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    // Halves are 2-byte aligned here, so the byte shift also places a half
    assign lane_mask = (size_q == 2'd0) ? (32'h0000_00FF << lane_sh)
                                        : (32'h0000_FFFF << lane_sh);
    assign merged    = (mem_rdata & ~lane_mask)
                     | ((wdata_q << lane_sh) & lane_mask);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    write_d  = req_write;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err)
                        state_d = S_RESP;
                    else if (!req_write)
                        state_d = S_RD;
                    else if (req_size == 2'd2)
                        state_d = S_WR;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_RD:       state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                rdata_d = load_val;
                state_d = S_RESP;
            end
            S_RMW_RD:   state_d = S_RMW_WAIT;
            S_RMW_WAIT: begin
                wdata_d = merged;
                state_d = S_WR;
            end
            S_WR:       state_d = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign mem_read    = (state_q == S_RD) || (state_q == S_RMW_RD);
    assign mem_write   = (state_q == S_WR);
    assign mem_address = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    assign mem_wdata   = mem_write ? wdata_q : '0;

    logic unused_write;
    assign unused_write = write_q;

endmodule
